// File: rtl/bus_terminal_fifo_if.sv
// bus_terminal_fifo_if: host and arbiter handshake signals of one bus terminal
interface bus_terminal_fifo_if #(
    parameter int pckg_sz = 16,
    parameter int depth = 8
);
    logic host_wr;
    logic [pckg_sz-1:0] host_din;
    logic host_full;
    logic pndng;
    logic pop;
    logic [pckg_sz-1:0] D_pop;
    logic push;
    logic [pckg_sz-1:0] D_push;
    logic rx_valid;
    logic [pckg_sz-1:0] rx_data;
    logic rx_rd;
    logic [$clog2(depth):0] tx_count;
    logic [2:0] err;
    modport master (
        output host_wr, host_din, pop, push, D_push, rx_rd,
        input host_full, pndng, D_pop, rx_valid, rx_data, tx_count, err
    );
    modport slave (
        input host_wr, host_din, pop, push, D_push, rx_rd,
        output host_full, pndng, D_pop, rx_valid, rx_data, tx_count, err
    );
endinterface

// File: rtl/bus_terminal_fifo.sv
// bus_terminal_fifo: TX/RX first-word-fall-through FIFO pair; BUS_TERM_ID_FILTER_EN enables the RX destination filter
module bus_terminal_fifo #(
    parameter int pckg_sz = 16,
    parameter int depth = 8,
    parameter logic [7:0] my_id = 8'h00,
    parameter logic [7:0] broadcast = 8'hFF
) (
    input logic clk,
    input logic rst,
    bus_terminal_fifo_if.slave bus
);
    localparam int aw = $clog2(depth);
    localparam int cw = aw + 1;
    logic [pckg_sz-1:0] tx_mem [depth];
    logic [pckg_sz-1:0] rx_mem [depth];
    logic [aw-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic [cw-1:0] tx_cnt, rx_cnt;
    logic [2:0] err_q;
    logic tx_empty, tx_full, rx_empty, rx_full;
    logic pop_ok, wr_ok, rd_ok, push_ok, id_ok;
`ifdef BUS_TERM_ID_FILTER_EN
    assign id_ok = bus.D_push[pckg_sz-1 -: 8] == my_id || bus.D_push[pckg_sz-1 -: 8] == broadcast;
`else
    logic unused_id;
    assign id_ok = 1'b1;
    assign unused_id = ^{my_id, broadcast};
`endif
    always_comb begin
        tx_empty = tx_cnt == '0;
        tx_full = tx_cnt == cw'(depth);
        rx_empty = rx_cnt == '0;
        rx_full = rx_cnt == cw'(depth);
        pop_ok = bus.pop && !tx_empty;
        wr_ok = bus.host_wr && (!tx_full || pop_ok);
        rd_ok = bus.rx_rd && !rx_empty;
        push_ok = bus.push && id_ok && (!rx_full || rd_ok);
    end
    // outputs depend only on registered state, so no input reaches an output combinationally
    assign bus.host_full = tx_full;
    assign bus.pndng = !tx_empty;
    assign bus.D_pop = tx_empty ? '0 : tx_mem[tx_rp];
    assign bus.rx_valid = !rx_empty;
    assign bus.rx_data = rx_empty ? '0 : rx_mem[rx_rp];
    assign bus.tx_count = tx_cnt;
    assign bus.err = err_q;
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_wp <= '0;
            tx_rp <= '0;
            rx_wp <= '0;
            rx_rp <= '0;
            tx_cnt <= '0;
            rx_cnt <= '0;
            err_q <= '0;
        end else begin
            if (wr_ok) tx_wp <= tx_wp + aw'(1);
            if (pop_ok) tx_rp <= tx_rp + aw'(1);
            if (push_ok) rx_wp <= rx_wp + aw'(1);
            if (rd_ok) rx_rp <= rx_rp + aw'(1);
            tx_cnt <= tx_cnt + cw'(wr_ok) - cw'(pop_ok);
            rx_cnt <= rx_cnt + cw'(push_ok) - cw'(rd_ok);
            err_q <= err_q | {bus.push && !push_ok, bus.pop && tx_empty, bus.host_wr && !wr_ok};
        end
    end
    always_ff @(posedge clk) begin
        if (rst && wr_ok) tx_mem[tx_wp] <= bus.host_din;
        if (rst && push_ok) rx_mem[rx_wp] <= bus.D_push;
    end
    a_dpop_stable: assert property (@(posedge clk) disable iff (!rst)
        bus.pndng && !bus.pop |=> $stable(bus.D_pop));
endmodule

// File: doc/bus_terminal_fifo.md
Name: bus_terminal_fifo

Overview:
- Per-terminal buffering stage between one host port and the shared bus generator/arbiter.
- TX side: a FIFO that host logic writes and the arbiter drains through its pndng/pop/D_pop handshake.
- RX side: a FIFO that captures packets the arbiter delivers through push/D_push, filtered on the destination ID, and that the host reads.
- The bench instantiates one per driver (drvrs copies) in place of the behavioural driver-side FIFOs.

Parameters:
- pckg_sz, 16, packet width in bits; destination ID is bits [pckg_sz-1 : pckg_sz-8].
- depth, 8, entries per FIFO (TX and RX); power of two, >= 2.
- my_id, 0, 8-bit terminal ID matched against the packet destination field.
- broadcast, 8'hFF, destination ID accepted by every terminal.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous reset, active-low (rst==0 at a posedge resets).
- host_wr  in  1  host write strobe into TX FIFO.
- host_din  in  pckg_sz  host packet to transmit.
- host_full  out  1  TX FIFO holds depth entries.
- pndng  out  1  TX FIFO non-empty (to arbiter).
- pop  in  1  arbiter consumes TX head.
- D_pop  out  pckg_sz  TX head packet (to arbiter).
- push  in  1  arbiter delivers a packet.
- D_push  in  pckg_sz  delivered packet.
- rx_valid  out  1  RX FIFO non-empty.
- rx_data  out  pckg_sz  RX head packet.
- rx_rd  in  1  host consumes RX head.
- tx_count  out  $clog2(depth)+1  TX occupancy.
- err  out  3  sticky flags: [0] TX overflow, [1] pop-underflow, [2] RX drop (full or misrouted).

Behaviour:
- Reset (rst==0 at posedge): pointers and counts = 0; pndng=0, host_full=0, D_pop=0, rx_valid=0, rx_data=0, tx_count=0, err=0. Reset is honoured mid-operation; contents are discarded and any same-cycle wr/pop/push/rd is ignored.
- Both FIFOs are first-word-fall-through with registered status:
  - host_wr accepted at edge N → pndng=1 and D_pop=host_din from N+1.
  - pop at edge N → next entry (or D_pop=0 and pndng=0 if emptied) from N+1.
- D_pop and rx_data read 0 whenever the corresponding FIFO is empty.
- TX write:
  - Accepted if not full, or if full and pop is asserted in the same cycle (count unchanged).
  - Otherwise dropped and err[0] set.
- TX pop:
  - Honoured only when pndng==1.
  - pop with pndng==0 is ignored and sets err[1].
  - Simultaneous host_wr+pop on empty: write accepted, pop ignored, err[1] set.
- RX push: accepted when D_push[pckg_sz-1:pckg_sz-8]==my_id or ==broadcast, and the RX FIFO is not full (or rx_rd is asserted the same cycle).
  - Any other push is dropped and sets err[2].
  - push with rx_rd on empty: push stored, rd ignored.
- Pointers wrap modulo depth. Occupancy uses a separate count (0..depth) so that full and empty are distinguishable.
- Arbiter-side D_pop is stable while pndng==1 and no pop occurs; this is a protocol invariant checked by assertion.
- err bits clear only on reset.
- No combinational path from any input to any output.

Optional Feature:
- Macro: BUS_TERM_ID_FILTER_EN.
- Defined: RX destination filter as described; misrouted packets are dropped and set err[2].
- Undefined: every push is accepted regardless of ID (subject only to full); err[2] is set only on RX-full drops. my_id and broadcast are unused.

Test Plan:
- Reset then idle: rst=0 for 5 cycles → all outputs 0. Release, no traffic → pndng=0, rx_valid=0 for 20 cycles.
- Write 16'h0A11, 16'h0B22, 16'h0C33 back-to-back → pndng=1 one cycle after the first write, D_pop=16'h0A11. Pop 3 times on consecutive cycles → D_pop sequence 0A11, 0B22, 0C33, then pndng=0, D_pop=0, tx_count=0.
- Fill TX with 8 writes → host_full=1, tx_count=8. Ninth write alone → dropped, err[0]=1. Write+pop same cycle while full → tx_count stays 8, new word appears last.
- pop with TX empty → err[1]=1, state unchanged, pndng stays 0.
- my_id=2, filter enabled: push 16'h0255, 16'hFF66, 16'h0377 → rx_data sequence 0255, FF66; err[2]=1. Same stimulus without the macro → all three stored.
- 8 writes queued, 3 popped, rst=0 for one cycle mid-stream → tx_count=0, pndng=0, err=0. Subsequent write 16'h0101 → D_pop=16'h0101 next cycle.
